laundry_coin_acceptor: RTL and testbench
========================================

Name: laundry_coin_acceptor

Overview:
Payment front-end for the laundry controller. It accepts coin pulses, accumulates credit and raises `paid` once the wash price is covered. The controller consumes `paid` as its payment-ok qualifier and returns `wash_done` when the spin phase completes. The block then issues change. It also refunds on user cancel or on inactivity timeout before payment completes.

Parameters:
- PRICE, 4, wash price in coin units.
- MAX_CREDIT, 7, highest credit the block will hold; a coin that would exceed it is rejected.
- CREDIT_W, 3, width of credit and change buses; must satisfy MAX_CREDIT < 2**CREDIT_W.
- TIMEOUT_CYC, 1000, idle cycles allowed in COLLECT before auto-refund.

Ports:
- clk, input, 1, system clock; all logic on its rising edge.
- reset, input, 1, asynchronous, active-low reset.
- coin_valid, input, 1, one-cycle strobe: a coin is present this cycle.
- coin_value, input, 2, coin worth in units (1..3); value 0 with coin_valid=1 is treated as an invalid coin.
- cancel, input, 1, user cancel request, level or pulse.
- wash_done, input, 1, one-cycle pulse from the controller at end of spin.
- paid, output, 1, level: credit covers PRICE and a wash is authorised.
- credit, output, CREDIT_W, current accumulated credit.
- coin_reject, output, 1, one-cycle pulse: the coin was returned and not added.
- change_valid, output, 1, one-cycle pulse: change_amount is valid.
- change_amount, output, CREDIT_W, units to dispense; held stable until the next change_valid.

Behaviour:
- Reset (reset=0, async): state=IDLE, credit=0, paid=0, coin_reject=0, change_valid=0, change_amount=0, timer=0.
  - Reset mid-wash discards credit and issues no refund.
- All outputs are registered. Every response appears the cycle after the causing input edge.
- States: IDLE, COLLECT, PAID, CHANGE.
- IDLE:
  - Valid coin: credit=coin_value, timer cleared. Next state is PAID if coin_value>=PRICE, else COLLECT.
  - Invalid coin: coin_reject pulse.
  - cancel and wash_done are ignored.
- COLLECT:
  - Valid coin with credit+coin_value<=MAX_CREDIT: add it and clear the timer. If the new credit>=PRICE, go to PAID on that same edge.
  - Coin that would overflow MAX_CREDIT, or an invalid coin: coin_reject pulse, credit unchanged.
  - cancel=1: change_valid pulse, change_amount=credit, credit=0, go to IDLE.
    - If a coin arrives in the same cycle, cancel wins and the coin is rejected (coin_reject=1).
  - Timer reaching TIMEOUT_CYC-1 with no coin: same refund as cancel.
  - Timer counts only in COLLECT and saturates; it never wraps.
- PAID:
  - paid=1.
  - Every coin is rejected; cancel is ignored because the wash is committed.
  - wash_done: go to CHANGE, paid deasserts on the same edge.
- CHANGE (single cycle):
  - change_valid=1, change_amount=credit-PRICE. The pulse is issued even when the amount is 0.
  - credit=0, go to IDLE.
  - A coin arriving in this cycle is rejected.
- Arithmetic:
  - Sums are computed at CREDIT_W+1 bits before comparing with MAX_CREDIT, so no silent wrap.
  - Change never underflows, because credit>=PRICE holds in PAID.
- wash_done outside PAID is ignored.
- coin_reject and change_valid can never be high longer than one cycle.

Decomposition:
- Shared package laundry_pkg holds:
  - the state encoding for IDLE/COLLECT/PAID/CHANGE (2-bit localparams);
  - the coin-unit constants;
  - the default PRICE.
- The package is shared with the controller so both agree on coin units.
- One natural sub-module: laundry_idle_timer (clear/enable/saturating counter, expired flag, parameter TIMEOUT_CYC).

Test Plan:
- Exact pay: PRICE=4; coins 2 then 2 -> credit 2 then 4; paid=1 the cycle after the second coin. wash_done -> change_valid=1 with change_amount=0; credit=0; back to IDLE.
- Overpay: coins 3 then 3 -> paid=1, credit=6. wash_done -> change_valid pulse with change_amount=2.
- Overflow reject: coins 3,3 give PAID at 6, then coin 1 -> coin_reject pulse, credit stays 6. Separately, with PRICE=8 and MAX_CREDIT=7, coins 3,3 then 2 -> third coin rejected, credit 6.
- Cancel: coin 1, then cancel and coin 2 in the same cycle -> coin_reject=1, change_valid=1, change_amount=1, credit=0, state IDLE.
- Timeout: TIMEOUT_CYC=16, coin 2, no activity -> refund pulse with amount 2 after exactly 16 cycles. A coin at cycle 10 restarts the count.
- Reset in PAID: reset asserted asynchronously mid-cycle -> paid, credit, change_valid all 0 immediately; after release, a wash_done pulse causes no change_valid.

Source files
------------

// File: rtl/laundry_pkg.sv
// Shared laundry definitions: FSM state encoding, coin units and default price.
// The wash controller imports this too, so both sides agree on what a coin unit is.
package laundry_pkg;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_PAID    = 2'd2;
  localparam logic [1:0] ST_CHANGE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE,
    COLLECT = ST_COLLECT,
    PAID    = ST_PAID,
    CHANGE  = ST_CHANGE
  } state_t;

  typedef logic [1:0] coin_unit_t;

  localparam coin_unit_t COIN_NONE  = 2'd0;
  localparam coin_unit_t COIN_ONE   = 2'd1;
  localparam coin_unit_t COIN_TWO   = 2'd2;
  localparam coin_unit_t COIN_THREE = 2'd3;

  localparam int DEFAULT_PRICE = 4;

  // A strobe carrying the zero code is a slug or misread coin, not a coin.
  function automatic logic coin_is_valid(input logic strobe, input coin_unit_t value);
    return strobe && (value != COIN_NONE);
  endfunction

endpackage

// File: rtl/laundry_coin_acceptor_if.sv
// Bus between the coin acceptor and whoever drives coins/cancel/wash_done.
// The acceptor takes the slave modport; the controller or bench takes master.
interface laundry_coin_acceptor_if
  import laundry_pkg::*;
#(
  parameter int CREDIT_W = 3
);

  logic                coin_valid;
  coin_unit_t          coin_value;
  logic                cancel;
  logic                wash_done;
  logic                paid;
  logic [CREDIT_W-1:0] credit;
  logic                coin_reject;
  logic                change_valid;
  logic [CREDIT_W-1:0] change_amount;

  modport master (
    output coin_valid, coin_value, cancel, wash_done,
    input  paid, credit, coin_reject, change_valid, change_amount
  );

  modport slave (
    input  coin_valid, coin_value, cancel, wash_done,
    output paid, credit, coin_reject, change_valid, change_amount
  );

endinterface

// File: rtl/laundry_idle_timer.sv
// Saturating inactivity counter; expired stays high once TIMEOUT_CYC-1 is reached
// until clear, so it can never wrap back into a false "still active" reading.
module laundry_idle_timer #(
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYC - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/laundry_coin_acceptor.sv
// Coin acceptor front-end: accumulates credit, raises paid at PRICE, refunds on
// cancel/timeout and dispenses change after wash_done. All outputs are registered.
module laundry_coin_acceptor
  import laundry_pkg::*;
#(
  parameter int PRICE       = DEFAULT_PRICE,
  parameter int MAX_CREDIT  = 7,
  parameter int CREDIT_W    = 3,
  parameter int TIMEOUT_CYC = 1000
) (
  input logic                    clk,
  input logic                    reset,
  laundry_coin_acceptor_if.slave bus
);

  localparam logic [CREDIT_W:0] MAX_SUM = MAX_CREDIT[CREDIT_W:0];

  state_t                state_q, state_d;
  logic [CREDIT_W-1:0]   credit_q, credit_d;
  logic [CREDIT_W-1:0]   change_amount_q, change_amount_d;
  logic                  paid_q, paid_d;
  logic                  coin_reject_q, coin_reject_d;
  logic                  change_valid_q, change_valid_d;

  logic                  coin_ok;
  logic                  coin_accept;
  logic                  timer_expired;
  logic [CREDIT_W:0]     sum;
  logic                  sum_over;
  logic                  sum_pays;
  logic                  coin_pays;
  logic [CREDIT_W-1:0]   change_due;

  // Sum is one bit wider than credit so an overflowing coin is seen, not wrapped.
  assign coin_ok    = coin_is_valid(bus.coin_valid, bus.coin_value);
  assign sum        = {1'b0, credit_q} + {{(CREDIT_W-1){1'b0}}, bus.coin_value};
  assign sum_over   = (sum > MAX_SUM);
  assign sum_pays   = (32'(sum) >= 32'(PRICE));
  assign coin_pays  = (32'(bus.coin_value) >= 32'(PRICE));
  assign change_due = CREDIT_W'(32'(credit_q) - 32'(PRICE));

  laundry_idle_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_idle_timer (
    .clk     (clk),
    .reset   (reset),
    .clear   ((state_q != COLLECT) || coin_accept),
    .enable  (state_q == COLLECT),
    .expired (timer_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q         <= IDLE;
      credit_q        <= '0;
      paid_q          <= 1'b0;
      coin_reject_q   <= 1'b0;
      change_valid_q  <= 1'b0;
      change_amount_q <= '0;
    end else begin
      state_q         <= state_d;
      credit_q        <= credit_d;
      paid_q          <= paid_d;
      coin_reject_q   <= coin_reject_d;
      change_valid_q  <= change_valid_d;
      change_amount_q <= change_amount_d;
    end
  end

  always_comb begin
    state_d         = state_q;
    credit_d        = credit_q;
    coin_reject_d   = 1'b0;
    change_valid_d  = 1'b0;
    change_amount_d = change_amount_q;
    coin_accept     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (coin_ok) begin
          credit_d    = CREDIT_W'(bus.coin_value);
          coin_accept = 1'b1;
          state_d     = coin_pays ? PAID : COLLECT;
        end else if (bus.coin_valid) begin
          coin_reject_d = 1'b1;
        end
      end

      // Cancel beats everything; an accepted coin beats the timeout on the same edge.
      COLLECT: begin
        if (bus.cancel || (timer_expired && !(coin_ok && !sum_over))) begin
          change_valid_d  = 1'b1;
          change_amount_d = credit_q;
          credit_d        = '0;
          coin_reject_d   = bus.coin_valid;
          state_d         = IDLE;
        end else if (coin_ok && !sum_over) begin
          credit_d    = sum[CREDIT_W-1:0];
          coin_accept = 1'b1;
          if (sum_pays) state_d = PAID;
        end else if (bus.coin_valid) begin
          coin_reject_d = 1'b1;
        end
      end

      PAID: begin
        coin_reject_d = bus.coin_valid;
        if (bus.wash_done) begin
          change_valid_d  = 1'b1;
          change_amount_d = change_due;
          credit_d        = '0;
          state_d         = CHANGE;
        end
      end

      CHANGE: begin
        coin_reject_d = bus.coin_valid;
        state_d       = IDLE;
      end

      default: state_d = IDLE;
    endcase

    paid_d = (state_d == PAID);
  end

  assign bus.paid          = paid_q;
  assign bus.credit        = credit_q;
  assign bus.coin_reject   = coin_reject_q;
  assign bus.change_valid  = change_valid_q;
  assign bus.change_amount = change_amount_q;

endmodule

// File: tb/tb_laundry_coin_acceptor.sv
// Directed scoreboard bench: one acceptor at PRICE=4/TIMEOUT=16, one at PRICE=8.
module tb_laundry_coin_acceptor;

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  typedef struct {
    string      tag;
    bit         sel;
    logic       paid;
    logic [2:0] credit;
    logic       coin_reject;
    logic       change_valid;
    logic [2:0] change_amount;
  } exp_t;

  exp_t sbq[$];

  laundry_coin_acceptor_if #(.CREDIT_W(3)) bus  ();
  laundry_coin_acceptor_if #(.CREDIT_W(3)) bus8 ();

  laundry_coin_acceptor #(
    .PRICE(4), .MAX_CREDIT(7), .CREDIT_W(3), .TIMEOUT_CYC(16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  laundry_coin_acceptor #(
    .PRICE(8), .MAX_CREDIT(7), .CREDIT_W(3), .TIMEOUT_CYC(16)
  ) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkField(input string tag, input string field,
                            input logic [2:0] obs, input logic [2:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s.%s observed=%0d expected=%0d", tag, field, obs, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sbq.size() == 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard observed=empty expected=entry");
      return;
    end
    e = sbq.pop_front();
    if (!e.sel) begin
      checkField(e.tag, "paid",          {2'b0, bus.paid},         {2'b0, e.paid});
      checkField(e.tag, "credit",        bus.credit,               e.credit);
      checkField(e.tag, "coin_reject",   {2'b0, bus.coin_reject},  {2'b0, e.coin_reject});
      checkField(e.tag, "change_valid",  {2'b0, bus.change_valid}, {2'b0, e.change_valid});
      checkField(e.tag, "change_amount", bus.change_amount,        e.change_amount);
    end else begin
      checkField(e.tag, "paid",          {2'b0, bus8.paid},         {2'b0, e.paid});
      checkField(e.tag, "credit",        bus8.credit,               e.credit);
      checkField(e.tag, "coin_reject",   {2'b0, bus8.coin_reject},  {2'b0, e.coin_reject});
      checkField(e.tag, "change_valid",  {2'b0, bus8.change_valid}, {2'b0, e.change_valid});
      checkField(e.tag, "change_amount", bus8.change_amount,        e.change_amount);
    end
  endtask

  task automatic clearInputs();
    bus.coin_valid  = 1'b0; bus.coin_value  = 2'd0; bus.cancel  = 1'b0; bus.wash_done  = 1'b0;
    bus8.coin_valid = 1'b0; bus8.coin_value = 2'd0; bus8.cancel = 1'b0; bus8.wash_done = 1'b0;
  endtask

  // Drives one cycle of inputs, records what the following edge must produce, then checks it.
  task automatic applyStimulus(input bit sel, input string tag,
                               input logic cv, input logic [1:0] val,
                               input logic can, input logic wd,
                               input logic e_paid, input logic [2:0] e_credit,
                               input logic e_rej, input logic e_cv,
                               input logic [2:0] e_amt);
    exp_t e;
    clearInputs();
    if (!sel) begin
      bus.coin_valid = cv;  bus.coin_value = val;  bus.cancel = can;  bus.wash_done = wd;
    end else begin
      bus8.coin_valid = cv; bus8.coin_value = val; bus8.cancel = can; bus8.wash_done = wd;
    end
    e.tag = tag; e.sel = sel; e.paid = e_paid; e.credit = e_credit;
    e.coin_reject = e_rej; e.change_valid = e_cv; e.change_amount = e_amt;
    sbq.push_back(e);
    @(posedge clk);
    #1;
    checkOutput();
    clearInputs();
  endtask

  initial begin
    reset = 1'b0;
    clearInputs();
    #12;
    checkField("reset", "paid",          {2'b0, bus.paid},         3'd0);
    checkField("reset", "credit",        bus.credit,               3'd0);
    checkField("reset", "coin_reject",   {2'b0, bus.coin_reject},  3'd0);
    checkField("reset", "change_valid",  {2'b0, bus.change_valid}, 3'd0);
    checkField("reset", "change_amount", bus.change_amount,        3'd0);
    checkField("reset8", "credit",       bus8.credit,              3'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] exact pay");
    applyStimulus(0, "exact_c1",   1, 2'd2, 0, 0,  0, 3'd2, 0, 0, 3'd0);
    applyStimulus(0, "exact_c2",   1, 2'd2, 0, 0,  1, 3'd4, 0, 0, 3'd0);
    applyStimulus(0, "exact_wash", 0, 2'd0, 0, 1,  0, 3'd0, 0, 1, 3'd0);
    applyStimulus(0, "exact_idle", 0, 2'd0, 0, 0,  0, 3'd0, 0, 0, 3'd0);

    $display("[TB] overpay and reject while paid");
    applyStimulus(0, "over_c1",     1, 2'd3, 0, 0,  0, 3'd3, 0, 0, 3'd0);
    applyStimulus(0, "over_c2",     1, 2'd3, 0, 0,  1, 3'd6, 0, 0, 3'd0);
    applyStimulus(0, "over_c3",     1, 2'd1, 0, 0,  1, 3'd6, 1, 0, 3'd0);
    applyStimulus(0, "over_cancel", 0, 2'd0, 1, 0,  1, 3'd6, 0, 0, 3'd0);
    applyStimulus(0, "over_wash",   0, 2'd0, 0, 1,  0, 3'd0, 0, 1, 3'd2);
    applyStimulus(0, "over_idle",   0, 2'd0, 0, 0,  0, 3'd0, 0, 0, 3'd2);

    $display("[TB] invalid coin and cancel");
    applyStimulus(0, "bad_coin",    1, 2'd0, 0, 0,  0, 3'd0, 1, 0, 3'd2);
    applyStimulus(0, "cancel_c1",   1, 2'd1, 0, 0,  0, 3'd1, 0, 0, 3'd2);
    applyStimulus(0, "cancel_hit",  1, 2'd2, 1, 0,  0, 3'd0, 1, 1, 3'd1);
    applyStimulus(0, "cancel_idle", 0, 2'd0, 0, 0,  0, 3'd0, 0, 0, 3'd1);
    applyStimulus(0, "idle_wash",   0, 2'd0, 0, 1,  0, 3'd0, 0, 0, 3'd1);

    $display("[TB] timeout");
    applyStimulus(0, "to_c1", 1, 2'd2, 0, 0,  0, 3'd2, 0, 0, 3'd1);
    for (int i = 1; i <= 16; i++)
      applyStimulus(0, "to_wait", 0, 2'd0, 0, 0,
                    0, (i == 16) ? 3'd0 : 3'd2, 0, (i == 16), (i == 16) ? 3'd2 : 3'd1);

    $display("[TB] timeout restart");
    applyStimulus(0, "tr_c1", 1, 2'd1, 0, 0,  0, 3'd1, 0, 0, 3'd2);
    for (int i = 1; i <= 9; i++)
      applyStimulus(0, "tr_wait1", 0, 2'd0, 0, 0,  0, 3'd1, 0, 0, 3'd2);
    applyStimulus(0, "tr_c2", 1, 2'd1, 0, 0,  0, 3'd2, 0, 0, 3'd2);
    for (int i = 1; i <= 16; i++)
      applyStimulus(0, "tr_wait2", 0, 2'd0, 0, 0,
                    0, (i == 16) ? 3'd0 : 3'd2, 0, (i == 16), 3'd2);

    $display("[TB] reset while paid");
    applyStimulus(0, "rp_c1", 1, 2'd3, 0, 0,  0, 3'd3, 0, 0, 3'd2);
    applyStimulus(0, "rp_c2", 1, 2'd1, 0, 0,  1, 3'd4, 0, 0, 3'd2);
    #3;
    reset = 1'b0;
    #1;
    checkField("rp_async", "paid",          {2'b0, bus.paid},         3'd0);
    checkField("rp_async", "credit",        bus.credit,               3'd0);
    checkField("rp_async", "change_valid",  {2'b0, bus.change_valid}, 3'd0);
    checkField("rp_async", "change_amount", bus.change_amount,        3'd0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(0, "rp_wash", 0, 2'd0, 0, 1,  0, 3'd0, 0, 0, 3'd0);

    $display("[TB] overflow in collect at price 8");
    applyStimulus(1, "p8_c1",     1, 2'd3, 0, 0,  0, 3'd3, 0, 0, 3'd0);
    applyStimulus(1, "p8_c2",     1, 2'd3, 0, 0,  0, 3'd6, 0, 0, 3'd0);
    applyStimulus(1, "p8_c3",     1, 2'd2, 0, 0,  0, 3'd6, 1, 0, 3'd0);
    applyStimulus(1, "p8_cancel", 0, 2'd0, 1, 0,  0, 3'd0, 0, 1, 3'd6);
    applyStimulus(1, "p8_idle",   0, 2'd0, 0, 0,  0, 3'd0, 0, 0, 3'd6);

    if (sbq.size() != 0) begin
      checks++;
      failures++;
      $error("[TB] FAIL scoreboard_drain observed=%0d expected=0", sbq.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
